// File: rtl/la_paritychk.sv
`default_nettype none
// ============================================================================
//  Module      : la_paritychk
//  Description : Two-stage valid/ready parity checker with sticky error flag
//                and saturating error counter.
//  Revision    : 1.0  initial release
// ============================================================================
module la_paritychk #(
    parameter         PROP = "DEFAULT",
    parameter int     DW   = 8,
    parameter int     ODD  = 0,
    parameter int     CW   = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_par,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_err,
    output logic          err_sticky,
    output logic [CW-1:0] err_count,
    input  logic          clear
);

    // Number of 3-bit groups covering {in_par, in_data}, last one zero-padded.
    localparam int       C_NG  = (DW + 3) / 3;
    localparam int       C_PW  = 3 * C_NG;
    localparam logic     C_ODD = (ODD != 0);
    localparam logic [CW-1:0] C_CNT_MAX = '1;

    logic            r_s1_valid;
    logic [DW-1:0]   r_s1_data;
    logic [C_NG-1:0] r_s1_pp;
    logic            r_s2_valid;
    logic [DW-1:0]   r_s2_data;
    logic            r_s2_err;
    logic            r_err_sticky;
    logic [CW-1:0]   r_err_count;

    logic            w_s2_load;
    logic            w_in_xfer;
    logic            w_out_xfer;
    logic            w_parity;
    logic [C_PW-1:0] w_grp;
    logic [C_NG-1:0] w_pp;

    // Technology-mapping tag only; no functional use.
    generate
        if ($bits(PROP) == 0) begin : g_prop_empty
        end
    endgenerate

    always_comb begin
        w_grp       = '0;
        w_grp[DW:0] = {in_par, in_data};
    end

    generate
        for (genvar g = 0; g < C_NG; g++) begin : g_pp
            assign w_pp[g] = ^w_grp[3*g +: 3];
        end
    endgenerate

    assign w_parity   = ^r_s1_pp;
    assign w_s2_load  = ~r_s2_valid | out_ready;
    assign in_ready   = ~r_s1_valid | w_s2_load;
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = r_s2_valid & out_ready;

    // Stage 1: capture word and per-group partial parities.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_xfer) begin
            r_s1_data <= in_data;
            r_s1_pp   <= w_pp;
        end
    end

    // Stage 2: fold partial parities into the final error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_err   <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_err <= w_parity ^ C_ODD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_s2_load & r_s1_valid) begin
            r_s2_data <= r_s1_data;
        end
    end

    // Clear wins over an errored transfer in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
        end else if (clear) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
        end else if (w_out_xfer & r_s2_err) begin
            r_err_sticky <= 1'b1;
            if (r_err_count != C_CNT_MAX) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_data   = r_s2_data;
    assign out_err    = r_s2_valid & r_s2_err;
    assign err_sticky = r_err_sticky;
    assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_la_paritychk.sv
`default_nettype none
// ============================================================================
//  Module      : tb_la_paritychk
//  Description : Directed and randomized bench for la_paritychk.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_la_paritychk;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DW=8, even parity, CW=8
    logic       a_in_valid, a_in_ready, a_in_par, a_out_valid, a_out_ready;
    logic [7:0] a_in_data, a_out_data, a_err_count;
    logic       a_out_err, a_err_sticky, a_clear;
    // Instance B: DW=8, odd parity, CW=2
    logic       b_in_valid, b_in_ready, b_in_par, b_out_valid, b_out_ready;
    logic [7:0] b_in_data, b_out_data;
    logic [1:0] b_err_count;
    logic       b_out_err, b_err_sticky, b_clear;

    la_paritychk #(.PROP("DEFAULT"), .DW(8), .ODD(0), .CW(8)) u_dut_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_par(a_in_par),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_err(a_out_err),
        .err_sticky(a_err_sticky), .err_count(a_err_count), .clear(a_clear)
    );

    la_paritychk #(.PROP("DEFAULT"), .DW(8), .ODD(1), .CW(2)) u_dut_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_par(b_in_par),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_err(b_out_err),
        .err_sticky(b_err_sticky), .err_count(b_err_count), .clear(b_clear)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state for instance A
    logic [8:0] q[$];
    int  m_cnt = 0;
    bit  m_sticky = 0;
    int  n_in = 0;
    int  n_out = 0;

    function automatic logic ref_err(input logic [7:0] d, input logic p, input int odd);
        int ones;
        ones = $countones({p, d});
        return (odd != 0) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock of instance A with scoreboard update and output checks.
    task automatic step_a();
        bit         in_x, out_x, stalled, e;
        logic [8:0] w;
        logic [7:0] prev_data;
        logic       prev_err;
        #1;
        in_x      = a_in_valid && a_in_ready;
        out_x     = a_out_valid && a_out_ready;
        stalled   = a_out_valid && !a_out_ready;
        prev_data = a_out_data;
        prev_err  = a_out_err;
        e = 1'b0;
        if (out_x) begin
            n_out++;
            if (q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                w = q.pop_front();
                e = ref_err(w[7:0], w[8], 0);
                check("out_data", a_out_data, w[7:0]);
                check("out_err", a_out_err, e);
            end
        end
        if (a_clear) begin
            m_cnt = 0;
            m_sticky = 0;
        end else if (out_x && e) begin
            m_sticky = 1;
            if (m_cnt < 255) m_cnt++;
        end
        if (in_x) begin
            q.push_back({a_in_par, a_in_data});
            n_in++;
        end
        tick();
        if (stalled) check("stall_stable", {a_out_valid, a_out_err, a_out_data}, {1'b1, prev_err, prev_data});
        check("err_count", a_err_count, m_cnt);
        check("err_sticky", a_err_sticky, m_sticky);
    endtask

    initial begin
        logic [7:0] w42 [4];
        logic [7:0] d;
        logic       p;
        int         idx, stall_left, exp_cnt;
        bit         first_done;

        a_in_valid = 0; a_in_data = 0; a_in_par = 0; a_out_ready = 1; a_clear = 0;
        b_in_valid = 0; b_in_data = 0; b_in_par = 0; b_out_ready = 1; b_clear = 0;

        // Asynchronous reset, observed before any clock edge
        #1 reset = 1'b1;
        #2;
        check("rst_out_valid", a_out_valid, 0);
        check("rst_in_ready", a_in_ready, 1);
        check("rst_err_count", a_err_count, 0);
        check("rst_err_sticky", a_err_sticky, 0);
        check("rst_out_err", a_out_err, 0);
        tick();
        tick();
        reset = 1'b0;

        // Single good word: 0xA5, even parity bit 0
        a_in_valid = 1; a_in_data = 8'hA5; a_in_par = 0;
        step_a();
        a_in_valid = 0;
        check("lat_edge1_valid", a_out_valid, 0);
        step_a();
        check("lat_edge2_valid", a_out_valid, 1);
        check("a5_data", a_out_data, 8'hA5);
        check("a5_err", a_out_err, 0);
        step_a();
        check("a5_gone", a_out_valid, 0);

        // Single bad word: 0x01 with parity 0
        a_in_valid = 1; a_in_data = 8'h01; a_in_par = 0;
        step_a();
        a_in_valid = 0;
        step_a();
        check("bad_err", a_out_err, 1);
        step_a();
        check("bad_cnt", a_err_count, 1);
        check("bad_sticky", a_err_sticky, 1);

        // Four back-to-back words with a 3-cycle downstream stall
        w42[0] = 8'h11; w42[1] = 8'h22; w42[2] = 8'h3C; w42[3] = 8'hF0;
        idx = 0; stall_left = 0; first_done = 0;
        n_out = 0;
        for (int c = 0; c < 16; c++) begin
            a_in_valid  = (idx < 4);
            a_in_data   = w42[idx % 4];
            a_in_par    = ^w42[idx % 4];
            a_out_ready = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                check("in_ready_full", a_in_ready, 0);
                stall_left--;
            end else if (!first_done && a_out_valid) begin
                first_done = 1;
                stall_left = 3;
            end
            if (a_in_valid && a_in_ready) idx++;
            step_a();
        end
        a_in_valid = 0;
        a_out_ready = 1;
        check("burst_outputs", n_out, 4);
        check("burst_drained", q.size(), 0);

        // Odd-parity instance with 2-bit saturating counter
        b_in_valid = 1; b_in_data = 8'h01; b_in_par = 0;
        tick();
        b_in_valid = 0;
        tick();
        check("b_good_err", b_out_err, ref_err(8'h01, 1'b0, 1));
        tick();
        check("b_good_cnt", b_err_count, 0);
        for (int k = 0; k < 5; k++) begin
            d = (k == 0) ? 8'h01 : 8'($urandom);
            p = (k == 0) ? 1'b1 : ^d;
            b_in_valid = 1; b_in_data = d; b_in_par = p;
            tick();
            b_in_valid = 0;
            tick();
            check("b_err", b_out_err, ref_err(d, p, 1));
            check("b_data", b_out_data, d);
            tick();
            exp_cnt = (k + 1 > 3) ? 3 : k + 1;
            check("b_sat_cnt", b_err_count, exp_cnt);
            check("b_sticky", b_err_sticky, 1);
        end
        d = 8'h0F;
        b_in_valid = 1; b_in_data = d; b_in_par = 1'b0;
        tick();
        b_in_valid = 0;
        tick();
        check("b_err6", b_out_err, ref_err(d, 1'b0, 1));
        b_clear = 1;
        tick();
        b_clear = 0;
        check("b_clr_cnt", b_err_count, 0);
        check("b_clr_sticky", b_err_sticky, 0);
        check("b_clr_forwarded", b_out_valid, 0);

        // Reset between edges with two words in flight
        a_in_valid = 1; a_in_data = 8'h5A; a_in_par = 1;
        step_a();
        a_in_data = 8'hC3; a_in_par = 0;
        step_a();
        a_in_valid = 0;
        check("inflight_valid", a_out_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("midrst_out_valid", a_out_valid, 0);
        check("midrst_err_count", a_err_count, 0);
        check("midrst_in_ready", a_in_ready, 1);
        q.delete();
        m_cnt = 0;
        m_sticky = 0;
        @(posedge clk);
        #2 reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step_a();
            check("post_rst_idle", a_out_valid, 0);
        end

        // Randomized traffic on both ports
        n_in = 0;
        for (int c = 0; c < 60000 && n_in < 10000; c++) begin
            a_in_valid  = ($urandom % 4) != 0;
            a_in_data   = 8'($urandom);
            a_in_par    = 1'($urandom);
            a_out_ready = ($urandom % 4) != 0;
            a_clear     = ($urandom % 256) == 0;
            step_a();
        end
        check("rand_accepted", n_in >= 10000, 1);
        a_in_valid = 0; a_out_ready = 1; a_clear = 0;
        for (int c = 0; c < 5; c++) step_a();
        check("rand_drained", q.size(), 0);
        check("rand_idle", a_out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
